// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte (LSB first, odd parity, stop) on device clock falling
// edges, then checks the device acknowledge bit.
// Optional build macro PS2_TX_RETRY_EN: one automatic retry of the same byte
// after a NACK or timeout before err is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  state_t            w_fail_state;

  logic              r_clk_meta, r_clk_sync, r_clk_prev;
  logic              r_dat_meta, r_dat_sync;
  logic              w_fall;
  logic              w_timeout;
  logic              w_accept;

  logic [7:0]        r_byte;
  logic              r_parity;
  logic [8:0]        r_shift;
  logic              r_drive;
  logic [3:0]        r_bit_cnt;
  logic [INH_W-1:0]  r_inh_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  assign w_timeout = (r_to_cnt == TO_LAST);
  assign w_accept  = (r_state == S_IDLE) && tx_valid;

`ifdef PS2_TX_RETRY_EN
  logic r_retried;

  // A first failure goes back to INHIBIT with the latched byte; only a second one is fatal.
  assign w_fail_state = r_retried ? S_ERR : S_INHIBIT;

  // Remember whether the current byte has already used its retry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retried <= 1'b0;
    end else if (w_accept) begin
      r_retried <= 1'b0;
    end else if (r_state != S_IDLE && w_state_next == S_INHIBIT) begin
      r_retried <= 1'b1;
    end
  end
`else
  assign w_fail_state = S_ERR;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; edges take priority over a coincident timeout.
  always_comb begin
    // NOTE: default first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:      if (tx_valid) w_state_next = S_INHIBIT;
      S_INHIBIT:   if (r_inh_cnt == INH_LAST) w_state_next = S_REQ;
      S_REQ:       w_state_next = S_DATA;
      S_DATA: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9) w_state_next = S_ACK;
        end else if (w_timeout) begin
          w_state_next = w_fail_state;
        end
      end
      S_ACK: begin
        if (w_fall)         w_state_next = r_dat_sync ? w_fail_state : S_WAIT_IDLE;
        else if (w_timeout) w_state_next = w_fail_state;
      end
      S_WAIT_IDLE: begin
        if (r_clk_sync && r_dat_sync) w_state_next = S_IDLE;
        else if (w_timeout)           w_state_next = w_fail_state;
      end
      S_ERR:       w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Line synchronizers, counters and the serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_shift    <= '0;
      r_drive    <= 1'b0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data_in;
      r_dat_sync <= r_dat_meta;

      r_inh_cnt <= (r_state == S_INHIBIT) ? r_inh_cnt + INH_W'(1) : '0;

      // Cleared before REQ so the count is zero in the REQ cycle itself.
      if (r_state == S_IDLE || r_state == S_INHIBIT || w_fall) r_to_cnt <= '0;
      else if (r_to_cnt != TO_LAST)                            r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_accept) begin
        r_byte   <= tx_data;
        r_parity <= ~^tx_data;
      end

      if (r_state == S_REQ) begin
        r_shift   <= {r_parity, r_byte};
        r_drive   <= 1'b1;
        r_bit_cnt <= '0;
      end else if (r_state == S_DATA && w_fall) begin
        // A released line sends a 1, so drive is the inverted bit; stop shifts in as 1.
        r_drive   <= ~r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
  assign ps2_data_oe = (r_state == S_REQ) || ((r_state == S_DATA) && r_drive);
  assign tx_ready    = (r_state == S_IDLE);
  assign done        = (r_state == S_WAIT_IDLE) && r_clk_sync && r_dat_sync;
  assign err         = (r_state == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: table of directed byte transfers against a
// wired-AND PS/2 device model, plus hand-written reset and retry sequences.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TO  = 200;
  localparam int H   = 8;   // device clock half period in system clocks
`ifdef PS2_TX_RETRY_EN
  localparam int FAIL_ATTEMPTS = 2;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, done, err;
  logic       clk_line, dat_line;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (dat_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor, sampled on the falling system clock edge.
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, req_cnt = 0;
  int req_cycle = 0, err_cycle = 0, inh_run = 0, inh_len = 0;
  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cycle = cyc;
    end
    if (done && err) both_cnt++;
    if (ps2_clk_oe && !ps2_data_oe) begin
      inh_run++;
    end else begin
      if (ps2_clk_oe && ps2_data_oe) begin
        req_cnt++;
        req_cycle = cyc;
        inh_len = inh_run;
      end
      inh_run = 0;
    end
  end

  // Device side: wait for request-to-send, clock n_edges falling edges,
  // capture the line on each rising edge, drive ACK (or NACK) for edge 11.
  task automatic dev_session(input int n_edges, input logic nack,
                             output logic [9:0] bits, output logic got);
    got  = 1'b0;
    bits = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ps2_data_oe && !ps2_clk_oe) got = 1'b1;
    end
    if (!got) return;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) dev_dat = nack;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) bits[k-1] = dat_line;
    end
    repeat (2) @(negedge clk);
    dev_dat = 1'b1;
    if (n_edges == 0)
      for (int i = 0; i < 400 && ps2_data_oe && !ps2_clk_oe; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (tx_ready) found = 1'b1;
    end
    check({tag, " ready_before"}, found, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    check({tag, " ready_low"}, tx_ready, 0);
    // Different data held valid while busy must be ignored.
    tx_data = ~b;
    repeat (4) @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (tx_ready) found = 1'b1;
    end
    check({tag, " ready_after"}, found, 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    int         n_edges;
    logic       nack;
    logic [9:0] exp_bits;   // {stop, parity, data} in wire order LSB first
    int         exp_done;
    int         exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int d0, e0, r0, attempts;
    logic [9:0] bits;
    logic got;
    d0 = done_cnt; e0 = err_cnt; r0 = req_cnt;
    attempts = (v.exp_err != 0) ? FAIL_ATTEMPTS : 1;
    send_byte(v.data, tag);
    for (int a = 0; a < attempts; a++) begin
      dev_session(v.n_edges, v.nack, bits, got);
      check({tag, " req_seen"}, got, 1);
    end
    wait_ready(tag);
    if (v.n_edges == 11) check({tag, " bits"}, bits, v.exp_bits);
    check({tag, " done"}, done_cnt - d0, v.exp_done);
    check({tag, " err"}, err_cnt - e0, v.exp_err);
    check({tag, " req_count"}, req_cnt - r0, attempts);
    check({tag, " inhibit_len"}, inh_len, INH);
    if (v.n_edges == 0) check({tag, " timeout_delay"}, err_cycle - req_cycle, TO);
  endtask

  vec_t vecs[5];
  vec_t v_f4;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic got;
    int d0, e0;

    vecs[0] = '{data: 8'hED, n_edges: 11, nack: 1'b0, exp_bits: 10'h3ED, exp_done: 1, exp_err: 0};
    vecs[1] = '{data: 8'h01, n_edges: 11, nack: 1'b0, exp_bits: 10'h201, exp_done: 1, exp_err: 0};
    vecs[2] = '{data: 8'h00, n_edges: 11, nack: 1'b0, exp_bits: 10'h300, exp_done: 1, exp_err: 0};
    vecs[3] = '{data: 8'hA5, n_edges: 0,  nack: 1'b0, exp_bits: 10'h000, exp_done: 0, exp_err: 1};
    vecs[4] = '{data: 8'h3C, n_edges: 11, nack: 1'b1, exp_bits: 10'h33C, exp_done: 0, exp_err: 1};
    v_f4    = '{data: 8'hF4, n_edges: 11, nack: 1'b0, exp_bits: 10'h2F4, exp_done: 1, exp_err: 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst tx_ready", tx_ready, 1);
    check("rst clk_oe", ps2_clk_oe, 0);
    check("rst data_oe", ps2_data_oe, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset after the fourth device edge of 0xF4 aborts silently.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4, "rstmid");
    dev_session(4, 1'b0, bits, got);
    check("rstmid req_seen", got, 1);
    check("rstmid busy", tx_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid clk_oe", ps2_clk_oe, 0);
    check("rstmid data_oe", ps2_data_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid tx_ready", tx_ready, 1);
    check("rstmid done", done_cnt - d0, 0);
    check("rstmid err", err_cnt - e0, 0);
    run_vec(v_f4, "after_rst");

`ifdef PS2_TX_RETRY_EN
    // NACK on the first attempt, ACK on the retry: done only.
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h5A, "retry");
    dev_session(11, 1'b1, bits, got);
    dev_session(11, 1'b0, bits, got);
    wait_ready("retry");
    check("retry bits", bits, 10'h35A);
    check("retry done", done_cnt - d0, 1);
    check("retry err", err_cnt - e0, 0);
`endif

    check("done_err_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clk cycles of PS/2 clock hold-low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, max clk cycles between consecutive device clock falling edges (15 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port ps2_clk_in  input  1  raw PS/2 CLOCK line level.
REQ-006 SHALL have port ps2_data_in  input  1  raw PS/2 DATA line level.
REQ-007 SHALL have port ps2_clk_oe  output  1  1 = pull CLOCK low (open-drain), 0 = release.
REQ-008 SHALL have port ps2_data_oe  output  1  1 = pull DATA low (open-drain), 0 = release.
REQ-009 SHALL have port tx_data  input  8  command byte to send to keyboard.
REQ-010 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-011 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse: byte acknowledged by device.
REQ-013 SHALL have port err  output  1  one-cycle pulse: NACK or timeout.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; device falling edge = synced CLOCK 1 then 0 on consecutive cycles.
REQ-015 SHALL accept on tx_valid && tx_ready; latch tx_data, compute odd parity (parity = ~^tx_data), enter INHIBIT; tx_ready low next cycle; tx_valid ignored while not ready.
REQ-016 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-017 REQ: one cycle ps2_data_oe=1 with ps2_clk_oe=1, then ps2_clk_oe=0 (data held low = start bit), enter DATA.
REQ-018 DATA: on falling edges 1..8 set ps2_data_oe = ~bit (LSB first); edge 9 drives parity; edge 10 releases DATA (stop bit); update on the cycle edge is detected.
REQ-019 ACK: on falling edge 11 sample synced DATA; 0 = ACK, go WAIT_IDLE; 1 = NACK, go ERR.
REQ-020 WAIT_IDLE: wait until synced CLOCK and DATA both 1, then pulse done, return IDLE.
REQ-021 Timeout counter SHALL reset on each falling edge and on REQ entry; reaching TIMEOUT_CYCLES in DATA, ACK or WAIT_IDLE goes ERR.
REQ-022 ERR: pulse err one cycle, both oe = 0, return IDLE.
REQ-023 Both oe SHALL be 0 in IDLE, WAIT_IDLE, ERR; done and err never high together.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter + 1; no wrap before terminal count.

Reset
REQ-025 On rst: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, done=0, err=0, counters and synchronizers (to 1) cleared, on the next rising edge.
REQ-026 Reset mid-transfer SHALL abort without done/err pulse; lines released on that edge.

Configuration
REQ-027 Macro PS2_TX_RETRY_EN: defined -> on first NACK/timeout, re-enter INHIBIT with same byte, err only if retry also fails; undefined -> err on first failure.

Verification (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200)
REQ-028 Send 0xED, device model clocks 11 edges, ACK low -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, single done pulse, tx_ready back high.
REQ-029 Send 0x01 -> parity 0; send 0x00 -> parity 1; clock held low exactly 10 cycles before DATA pulled low.
REQ-030 Device never clocks -> err pulse 200 cycles after REQ (macro undefined); with PS2_TX_RETRY_EN, second INHIBIT then err.
REQ-031 Device leaves DATA high on edge 11 -> err pulse, no done; with PS2_TX_RETRY_EN and ACK on retry -> done only.
REQ-032 rst asserted after edge 4 of 0xF4 -> both oe 0 next cycle, no done/err, next send 0xF4 completes normally.
